// File: rtl/despertador_alarm_pkg.sv
// -----------------------------------------------------------------------------
// despertador_alarm_pkg
//   Shared definitions for the alarm table scanner: bit positions and widths of
//   the fields inside one 32-bit alarm entry, the terminator word, and the
//   scanner FSM state encoding.
//
//   Entry layout: [31] en, [30:24] day mask (bit n = weekday n),
//                 [20:16] hour, [13:8] minute, all other bits ignored.
// -----------------------------------------------------------------------------
package despertador_alarm_pkg;

  localparam int ENTRY_W  = 32;
  localparam int EN_BIT   = 31;
  localparam int DAY_LSB  = 24;
  localparam int DAY_W    = 7;
  localparam int HOUR_LSB = 16;
  localparam int HOUR_W   = 5;
  localparam int MIN_LSB  = 8;
  localparam int MIN_W    = 6;
  localparam int WDAY_W   = 3;

  // An all-zero word ends the table; nothing past it is read.
  localparam logic [ENTRY_W-1:0] TERMINATOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } scan_state_t;

  function automatic logic is_terminator(input logic [ENTRY_W-1:0] entry);
    return entry == TERMINATOR;
  endfunction

endpackage

// File: rtl/despertador_alarm_scanner_if.sv
// -----------------------------------------------------------------------------
// despertador_alarm_scanner_if
//   Avalon-MM read-only link between the alarm scanner (master) and the alarm
//   memory (slave).
//
//   Handshake: the master raises read with a stable address; the request is
//   accepted on the rising edge where read=1 and waitrequest=0, and until then
//   address and read must not change. readdatavalid qualifies readdata; the
//   alarm memory returns data one cycle after acceptance. At most one read is
//   outstanding.
//
//   Signals: address[ADDR_W], read, byteenable[4] (master -> slave);
//            waitrequest, readdata[32], readdatavalid (slave -> master).
// -----------------------------------------------------------------------------
interface despertador_alarm_scanner_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic [3:0]        byteenable;
  logic              waitrequest;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/despertador_alarm_scanner_match.sv
// -----------------------------------------------------------------------------
// alarm_entry_match
//   Combinational compare of one alarm entry against the time latched at scan
//   start. Optional macro ALARM_SCAN_WEEKDAY_EN: when defined, the entry's day
//   mask bit for the latched weekday must also be set; when undefined the day
//   mask is ignored and an entry matches on every day.
//
//   Inputs : entry_en, entry_days[7], entry_hour[5], entry_minute[6],
//            lat_hour[5], lat_minute[6], lat_weekday[3]
//   Output : match
// -----------------------------------------------------------------------------
module alarm_entry_match
  import despertador_alarm_pkg::*;
(
  input  logic              entry_en,
  input  logic [DAY_W-1:0]  entry_days,
  input  logic [HOUR_W-1:0] entry_hour,
  input  logic [MIN_W-1:0]  entry_minute,
  input  logic [HOUR_W-1:0] lat_hour,
  input  logic [MIN_W-1:0]  lat_minute,
  input  logic [WDAY_W-1:0] lat_weekday,
  output logic              match
);

  logic day_ok;

`ifdef ALARM_SCAN_WEEKDAY_EN
  // Padded to 8 bits so a weekday code of 7 selects a constant 0.
  logic [7:0] day_sel;
  assign day_sel = {1'b0, entry_days};
  assign day_ok  = day_sel[lat_weekday];
`else
  // Day fields carry no meaning in this build.
  logic unused_day_fields;
  assign unused_day_fields = ^{entry_days, lat_weekday};
  assign day_ok = 1'b1;
`endif

  // Stored hour/minute outside 0..23 / 0..59 can never equal the latched
  // (always in-range) time, so no separate range check is needed.
  assign match = entry_en & day_ok &
                 (entry_hour == lat_hour) & (entry_minute == lat_minute);

endmodule

// File: rtl/despertador_alarm_scanner.sv
// -----------------------------------------------------------------------------
// despertador_alarm_scanner
//   On each minute tick (when enabled) walks the alarm table in on-chip memory
//   through an Avalon-MM read master, compares every entry with the time
//   latched at scan start and pulses alarm_hit/alarm_idx for each match.
//   Optional macro ALARM_SCAN_WEEKDAY_EN adds the weekday mask to the match
//   (handled inside alarm_entry_match); ports are identical either way.
//
//   Ports:
//     clk, reset                  clock, asynchronous active-high reset
//     enable, minute_tick         scan start qualifier and trigger
//     cur_hour/minute/weekday     current time, latched at scan start
//     avm (master modport)        Avalon-MM read path to the alarm memory
//     alarm_hit, alarm_idx        one-cycle pulse + index per matching entry
//     scan_busy, scan_done        scan in progress / one-cycle end pulse
//     tick_overrun, overrun_clr   sticky "tick while busy" flag and its clear
//     state_dbg                   current FSM state
// -----------------------------------------------------------------------------
module despertador_alarm_scanner
  import despertador_alarm_pkg::*;
#(
  parameter int BASE_ADDR   = 0,
  parameter int NUM_ENTRIES = 16,
  parameter int ADDR_W      = 10,
  parameter int IDX_W       = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  minute_tick,
  input  logic [HOUR_W-1:0]     cur_hour,
  input  logic [MIN_W-1:0]      cur_minute,
  input  logic [WDAY_W-1:0]     cur_weekday,
  despertador_alarm_scanner_if.master avm,
  output logic                  alarm_hit,
  output logic [IDX_W-1:0]      alarm_idx,
  output logic                  scan_busy,
  output logic                  scan_done,
  output logic                  tick_overrun,
  input  logic                  overrun_clr,
  output scan_state_t           state_dbg
);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [ADDR_W-1:0] BASE_WORD = ADDR_W'(BASE_ADDR);

  scan_state_t       state;
  logic [IDX_W-1:0]  idx;
  logic [HOUR_W-1:0] lat_hour;
  logic [MIN_W-1:0]  lat_minute;
  logic [WDAY_W-1:0] lat_weekday;
  logic [ADDR_W-1:0] addr_q;
  logic              read_q;

  logic entry_hit;
  logic entry_end;
  logic overrun_set;

  alarm_entry_match u_match (
    .entry_en     (avm.readdata[EN_BIT]),
    .entry_days   (avm.readdata[DAY_LSB +: DAY_W]),
    .entry_hour   (avm.readdata[HOUR_LSB +: HOUR_W]),
    .entry_minute (avm.readdata[MIN_LSB +: MIN_W]),
    .lat_hour     (lat_hour),
    .lat_minute   (lat_minute),
    .lat_weekday  (lat_weekday),
    .match        (entry_hit)
  );

  assign entry_end = is_terminator(avm.readdata) || (idx == LAST_IDX);

  // scan_busy is still high in DONE, so a tick landing there counts as overrun.
  assign overrun_set = minute_tick & scan_busy;

  assign avm.address    = addr_q;
  assign avm.read       = read_q;
  assign avm.byteenable = 4'hF;
  assign state_dbg      = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      lat_hour     <= '0;
      lat_minute   <= '0;
      lat_weekday  <= '0;
      addr_q       <= BASE_WORD;
      read_q       <= 1'b0;
      alarm_hit    <= 1'b0;
      alarm_idx    <= '0;
      scan_busy    <= 1'b0;
      scan_done    <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      alarm_hit <= 1'b0;
      scan_done <= 1'b0;

      // A new overrun beats a simultaneous clear.
      if (overrun_set) begin
        tick_overrun <= 1'b1;
      end else if (overrun_clr) begin
        tick_overrun <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (minute_tick && enable) begin
            lat_hour    <= cur_hour;
            lat_minute  <= cur_minute;
            lat_weekday <= cur_weekday;
            idx         <= '0;
            addr_q      <= BASE_WORD;
            read_q      <= 1'b1;
            scan_busy   <= 1'b1;
            state       <= ST_REQ;
          end
        end

        ST_REQ: begin
          // Address and read are left untouched while the slave stalls.
          if (!avm.waitrequest) begin
            read_q <= 1'b0;
            state  <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (avm.readdatavalid) begin
            if (entry_hit) begin
              alarm_hit <= 1'b1;
              alarm_idx <= idx;
            end
            if (entry_end) begin
              scan_done <= 1'b1;
              state     <= ST_DONE;
            end else begin
              idx    <= idx + IDX_W'(1);
              addr_q <= BASE_WORD + ADDR_W'(idx + IDX_W'(1));
              read_q <= 1'b1;
              state  <= ST_REQ;
            end
          end
        end

        ST_DONE: begin
          scan_busy <= 1'b0;
          state     <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_despertador_alarm_scanner.sv
// -----------------------------------------------------------------------------
// tb_despertador_alarm_scanner
//   Directed bench for the alarm scanner: a behavioural alarm memory with
//   programmable wait states, a table of scan vectors with hand-computed hits,
//   read counts and scan_done cycles, plus sequences for overrun handling and
//   asynchronous reset in the middle of a read.
// -----------------------------------------------------------------------------
module tb_despertador_alarm_scanner;
  import despertador_alarm_pkg::*;

  localparam int ADDR_W  = 10;
  localparam int IDX_W   = 10;
  localparam int TB_BASE = 32;
  localparam int N_ENT   = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              enable = 1'b0;
  logic              minute_tick = 1'b0;
  logic [4:0]        cur_hour = '0;
  logic [5:0]        cur_minute = '0;
  logic [2:0]        cur_weekday = '0;
  logic              overrun_clr = 1'b0;
  logic              alarm_hit;
  logic [IDX_W-1:0]  alarm_idx;
  logic              scan_busy;
  logic              scan_done;
  logic              tick_overrun;
  scan_state_t       state_dbg;

  despertador_alarm_scanner_if #(.ADDR_W(ADDR_W)) avm ();

  despertador_alarm_scanner #(
    .BASE_ADDR   (TB_BASE),
    .NUM_ENTRIES (N_ENT),
    .ADDR_W      (ADDR_W),
    .IDX_W       (IDX_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .minute_tick  (minute_tick),
    .cur_hour     (cur_hour),
    .cur_minute   (cur_minute),
    .cur_weekday  (cur_weekday),
    .avm          (avm),
    .alarm_hit    (alarm_hit),
    .alarm_idx    (alarm_idx),
    .scan_busy    (scan_busy),
    .scan_done    (scan_done),
    .tick_overrun (tick_overrun),
    .overrun_clr  (overrun_clr),
    .state_dbg    (state_dbg)
  );

  // ---------------- alarm memory model ----------------
  logic [31:0] mem [0:1023];
  int ws = 0;
  int stall_cnt = 0;
  int rd_total = 0;
  int rd_log [0:1023];

  assign avm.waitrequest = avm.read && (stall_cnt != 0);

  always @(posedge clk) begin
    avm.readdatavalid <= 1'b0;
    if (!avm.read) begin
      stall_cnt <= ws;
    end else if (stall_cnt != 0) begin
      stall_cnt <= stall_cnt - 1;
    end else begin
      avm.readdata      <= mem[avm.address];
      avm.readdatavalid <= 1'b1;
      rd_log[rd_total]  <= int'(avm.address);
      rd_total          <= rd_total + 1;
      stall_cnt         <= ws;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [IDX_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic en, input logic [6:0] days,
                                     input logic [4:0] h, input logic [5:0] m,
                                     input logic [7:0] junk);
    return {en, days, 3'b101, h, 2'b11, m, junk};
  endfunction

  task automatic load_image(input int img);
    for (int i = 0; i < 32; i++) mem[TB_BASE + i] = 32'h0;
    case (img)
      0: begin
        mem[TB_BASE + 0] = mk(1'b1, 7'h7F, 5'd7, 6'd30, 8'h00);
        mem[TB_BASE + 1] = mk(1'b1, 7'h7F, 5'd7, 6'd31, 8'h3C);
        mem[TB_BASE + 2] = 32'h0;
        mem[TB_BASE + 3] = mk(1'b1, 7'h7F, 5'd7, 6'd30, 8'h00);
      end
      1: begin
        for (int i = 0; i < N_ENT; i++) mem[TB_BASE + i] = mk(1'b1, 7'h7F, 5'd7, 6'(i), 8'h00);
        mem[TB_BASE + 3]  = mk(1'b0, 7'h7F, 5'd6, 6'd0, 8'h00);   // disabled
        mem[TB_BASE + 5]  = mk(1'b1, 7'h7F, 5'd6, 6'd0, 8'hA5);
        mem[TB_BASE + 9]  = mk(1'b1, 7'h7F, 5'd31, 6'd63, 8'h00); // out of range
        mem[TB_BASE + 12] = mk(1'b1, 7'h7F, 5'd6, 6'd0, 8'h00);
        mem[TB_BASE + 15] = mk(1'b1, 7'h7F, 5'd6, 6'd1, 8'h00);
        mem[TB_BASE + 16] = mk(1'b1, 7'h7F, 5'd6, 6'd0, 8'h00);   // past NUM_ENTRIES
      end
      default: begin
        mem[TB_BASE + 0] = mk(1'b1, 7'b0000010, 5'd8, 6'd0, 8'h00);
        mem[TB_BASE + 1] = 32'h0;
        mem[TB_BASE + 2] = mk(1'b1, 7'h7F, 5'd8, 6'd0, 8'h00);
      end
    endcase
  endtask

  typedef struct {
    int         img;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [2:0] wd;
    int         ws;
    logic       en;
    logic [15:0] mask;
    int         reads;
    int         done_cyc;
  } vec_t;

  vec_t vecs [10];

  // ---------------- driver: one complete scan ----------------
  // Cycle 1 is the cycle in which minute_tick is high.
  task automatic run_scan(input vec_t v, input int xtick, input int xclr, input string tag);
    int cyc, done_cnt, done_at, start_rd, stall_bad, addr_bad, n_rd;
    logic prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    logic [IDX_W-1:0] got_q[$];
    load_image(v.img);
    ws = v.ws;
    done_cnt = 0; done_at = 0; stall_bad = 0; prev_stall = 1'b0; prev_addr = '0;
    @(negedge clk);
    enable = v.en; cur_hour = v.hour; cur_minute = v.minute; cur_weekday = v.wd;
    minute_tick = 1'b1; cyc = 1; start_rd = rd_total;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      cyc++;
      if (prev_stall && !(avm.read && avm.address == prev_addr)) stall_bad++;
      prev_stall = avm.read && avm.waitrequest;
      prev_addr  = avm.address;
      if (alarm_hit) got_q.push_back(alarm_idx);
      if (scan_done) begin
        done_cnt++;
        if (done_at == 0) done_at = cyc;
      end
      if (cyc == 2) begin
        check({tag, " busy_start"}, scan_busy, v.en);
        minute_tick = 1'b0;
        // Time moves on mid-scan; the scan must keep the latched value.
        cur_hour = v.hour ^ 5'd1;
        cur_minute = (v.minute == 6'd59) ? 6'd0 : v.minute + 6'd1;
        cur_weekday = v.wd + 3'd1;
      end
      if (xtick != 0 && cyc == xtick) minute_tick = 1'b1;
      if (xtick != 0 && cyc == xtick + 1) minute_tick = 1'b0;
      if (xclr != 0 && cyc == xclr) overrun_clr = 1'b1;
      if (xclr != 0 && cyc == xclr + 1) overrun_clr = 1'b0;
      if (done_at != 0 && cyc == done_at + 5) break;
      if (!v.en && cyc >= 12) break;
    end
    minute_tick = 1'b0;
    overrun_clr = 1'b0;
    n_rd = rd_total - start_rd;
    check({tag, " reads"}, n_rd, v.reads);
    addr_bad = 0;
    for (int i = 0; i < n_rd; i++) if (rd_log[start_rd + i] != TB_BASE + i) addr_bad++;
    check({tag, " addr_seq"}, addr_bad, 0);
    check({tag, " done_count"}, done_cnt, v.en ? 1 : 0);
    if (v.en) check({tag, " done_cycle"}, done_at, v.done_cyc);
    check({tag, " stall_stable"}, stall_bad, 0);
    check({tag, " busy_after"}, scan_busy, 0);
    exp_q.delete();
    for (int i = 0; i < N_ENT; i++) if (v.mask[i]) exp_q.push_back(IDX_W'(i));
    check({tag, " hit_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, " hit_idx"}, got_q.pop_front(), exp_q.pop_front());
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int found, spurious;

    vecs[0] = '{0, 5'd7, 6'd30, 3'd3, 0, 1'b1, 16'h0001, 3, 8};
    vecs[1] = '{0, 5'd7, 6'd31, 3'd3, 0, 1'b1, 16'h0002, 3, 8};
    vecs[2] = '{0, 5'd7, 6'd32, 3'd0, 1, 1'b1, 16'h0000, 3, 11};
    vecs[3] = '{1, 5'd6, 6'd0,  3'd0, 0, 1'b1, 16'h1020, 16, 34};
    vecs[4] = '{1, 5'd6, 6'd0,  3'd6, 3, 1'b1, 16'h1020, 16, 82};
    vecs[5] = '{1, 5'd6, 6'd1,  3'd2, 0, 1'b1, 16'h8000, 16, 34};
    vecs[6] = '{1, 5'd7, 6'd4,  3'd4, 2, 1'b1, 16'h0010, 16, 66};
    vecs[7] = '{2, 5'd8, 6'd0,  3'd1, 0, 1'b1, 16'h0001, 2, 6};
`ifdef ALARM_SCAN_WEEKDAY_EN
    vecs[8] = '{2, 5'd8, 6'd0,  3'd2, 0, 1'b1, 16'h0000, 2, 6};
`else
    vecs[8] = '{2, 5'd8, 6'd0,  3'd2, 0, 1'b1, 16'h0001, 2, 6};
`endif
    vecs[9] = '{1, 5'd6, 6'd0,  3'd0, 0, 1'b0, 16'h0000, 0, 0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst alarm_hit", alarm_hit, 0);
    check("rst alarm_idx", alarm_idx, 0);
    check("rst scan_busy", scan_busy, 0);
    check("rst scan_done", scan_done, 0);
    check("rst tick_overrun", tick_overrun, 0);
    check("rst avm_read", avm.read, 0);
    check("rst avm_address", avm.address, TB_BASE);
    check("rst byteenable", avm.byteenable, 4'hF);
    check("rst state", state_dbg, ST_IDLE);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven scans
    for (int i = 0; i < 10; i++) run_scan(vecs[i], 0, 0, $sformatf("vec%0d", i));

    // Tick while busy: flagged, no rescan
    run_scan(vecs[3], 6, 0, "ovr_busy");
    check("ovr_busy flag", tick_overrun, 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_clr", tick_overrun, 0);

    // Tick in the DONE cycle is also an overrun
    run_scan(vecs[3], 34, 0, "ovr_done");
    check("ovr_done flag", tick_overrun, 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_clr2", tick_overrun, 0);

    // Set and clear in the same cycle: set wins
    run_scan(vecs[3], 10, 10, "ovr_both");
    check("ovr_both flag", tick_overrun, 1);

    // Asynchronous reset while entry 5 (a hit) is being returned
    load_image(1);
    ws = 0;
    @(negedge clk);
    enable = 1'b1; cur_hour = 5'd6; cur_minute = 6'd0; cur_weekday = 3'd0;
    minute_tick = 1'b1;
    @(negedge clk);
    minute_tick = 1'b0;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      if (state_dbg == ST_WAIT && avm.address == ADDR_W'(TB_BASE + 5)) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("mid_rst reached_wait", found, 1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst scan_busy", scan_busy, 0);
    check("mid_rst avm_read", avm.read, 0);
    check("mid_rst alarm_hit", alarm_hit, 0);
    check("mid_rst scan_done", scan_done, 0);
    check("mid_rst tick_overrun", tick_overrun, 0);
    check("mid_rst avm_address", avm.address, TB_BASE);
    check("mid_rst state", state_dbg, ST_IDLE);
    @(negedge clk);
    reset = 1'b0;
    spurious = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (alarm_hit || scan_done || avm.read || scan_busy) spurious++;
    end
    check("post_rst quiet", spurious, 0);
    run_scan(vecs[3], 0, 0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
